// File: rtl/zap_wb_pkg.sv
// Shared definitions for the Wishbone RAM slave.
// Contents: Wishbone cycle-type codes and the slave FSM state encoding.
package zap_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLASSIC = 2'd1,
        ST_BURST   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/zap_ram_byte_array.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
// Ports:
//   clk   - clock
//   we    - byte write enables, bit n writes wdata[8n+7:8n]
//   addr  - word address
//   wdata - write data
//   rdata - registered read data, one cycle after addr is presented;
//           a read of the word being written returns the old contents
module zap_ram_byte_array #(
    parameter int DEPTH     = 16384,
    parameter int AW        = $clog2(DEPTH),
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // Power-up contents: cleared, or left undefined when clearing is not wanted.
    localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx;

    logic [31:0] mem [DEPTH] = '{default: INIT_WORD};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/zap_wb_ram.sv
// Wishbone B3 slave RAM used as main memory. Handles classic cycles and
// linear incrementing bursts (CTI=010) with one beat per cycle.
// Ports:
//   i_clk, i_reset  - clock, synchronous active-high reset
//   i_wb_cyc/stb    - bus cycle / strobe
//   i_wb_adr        - byte address (low two bits ignored, upper bits alias)
//   i_wb_we/sel     - write enable / byte lanes
//   i_wb_cti        - cycle type: 000 classic, 010 incrementing, 111 end of burst
//   i_wb_dat        - write data
//   o_wb_ack        - registered acknowledge
//   o_wb_dat        - read data, valid with o_wb_ack, holds otherwise
module zap_wb_ram
    import zap_wb_pkg::*;
#(
    parameter int SIZE_BYTES = 65536,
    parameter int INIT_ZERO  = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic [31:0] i_wb_adr,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [2:0]  i_wb_cti,
    input  logic [31:0] i_wb_dat,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_dat
);

    localparam int ABITS = $clog2(SIZE_BYTES);
    localparam int AW    = ABITS - 2;
    localparam int DEPTH = SIZE_BYTES / 4;

    wb_state_t      state;
    logic           ack_q;
    logic [31:0]    dat_hold;
    logic           req;
    logic [AW-1:0]  word_idx;
    logic [AW-1:0]  ram_addr;
    logic [3:0]     ram_we;
    logic [31:0]    ram_rdata;
    logic           unused_adr;

    assign req        = i_wb_cyc & i_wb_stb;
    assign word_idx   = i_wb_adr[ABITS-1:2];
    assign unused_adr = ^{i_wb_adr[31:ABITS], i_wb_adr[1:0]};

    // While a burst beat is being acked the master still shows that beat's
    // address, so reads fetch the following word to keep one beat per cycle.
    // Writes always land at the address on the bus; the first beat is written
    // twice, which is harmless. Word index arithmetic wraps at the memory size.
    always_comb begin
        ram_addr = word_idx;
        ram_we   = 4'b0000;
        if (!i_reset && req) begin
            unique case (state)
                ST_IDLE: begin
                    if (i_wb_we) ram_we = i_wb_sel;
                end
                ST_BURST: begin
                    if (i_wb_we) ram_we = i_wb_sel;
                    else         ram_addr = word_idx + AW'(1);
                end
                default: ;
            endcase
        end
    end

    zap_ram_byte_array #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_ZERO (INIT_ZERO != 0)
    ) u_ram (
        .clk   (i_clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (i_wb_dat),
        .rdata (ram_rdata)
    );

    // The RAM output register changes on every cycle, so the bus data is taken
    // from it only while acking and otherwise replays the last value shown.
    assign o_wb_ack = ack_q;
    assign o_wb_dat = ack_q ? ram_rdata : dat_hold;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            ack_q    <= 1'b0;
            dat_hold <= '0;
        end else begin
            dat_hold <= o_wb_dat;
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        ack_q <= 1'b1;
                        state <= (i_wb_cti == CTI_INCR) ? ST_BURST : ST_CLASSIC;
                    end else begin
                        ack_q <= 1'b0;
                    end
                end
                ST_CLASSIC: begin
                    ack_q <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_BURST: begin
                    // Dropping stb mid-burst is treated the same as dropping cyc.
                    if (req && i_wb_cti == CTI_INCR) begin
                        ack_q <= 1'b1;
                    end else begin
                        ack_q <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    ack_q <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
